// File: rtl/wiegand_tx_ctrl.sv
// Wiegand-26 frame scheduler for two requesters: round-robin grant, frame/parity
// build, transmitter enable/data drive, completion/timeout handling, inter-frame gap.
// Latency: ack one cycle after req seen in IDLE; done/err one cycle after completion/timeout.
// Backpressure: requests are held (level) and only granted in IDLE; SEND/GAP stall them.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-low reset
//   req[1:0]       level request per requester (0: host MCU, 1: local reader path)
//   payload0/1     24-bit {facility[7:0], card[15:0]}, sampled at grant
//   ack[1:0]       one-cycle grant pulse (payload latched)
//   done[1:0]      one-cycle frame-complete pulse for the granted requester
//   err            one-cycle SEND timeout pulse (frame aborted)
//   busy           state != IDLE
//   tx_en          transmitter enable, high for the whole SEND phase
//   tx_data[25:0]  frame, tx_data[0] sent first
//   tx_int_n       transmitter completion window, active-low, sampled only in SEND
module wiegand_tx_ctrl #(
  parameter int unsigned GAP_CYCLES = 1000,
  parameter int unsigned TIMEOUT    = 3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [23:0] payload0,
  input  logic [23:0] payload1,
  output logic [1:0]  ack,
  output logic [1:0]  done,
  output logic        err,
  output logic        busy,
  output logic        tx_en,
  output logic [25:0] tx_data,
  input  logic        tx_int_n
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SEND = 2'b01,
    S_GAP  = 2'b10
  } state_t;

  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        last_grant_q, last_grant_d;
  logic        cur_q, cur_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  done_q, done_d;
  logic        err_q, err_d;
  logic        tx_en_q, tx_en_d;
  logic [25:0] tx_data_q, tx_data_d;
  logic        grant;

  // Payload is sent MSB first after a leading even-parity bit over the upper
  // 12 data bits; a trailing odd-parity bit covers the lower 12 data bits.
  function automatic logic [25:0] build_frame(input logic [23:0] p);
    logic [25:0] f;
    f[0] = ^p[23:12];
    for (int k = 0; k < 24; k++) begin
      f[k+1] = p[23-k];
    end
    f[25] = ~^p[11:0];
    return f;
  endfunction

  // A lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    grant = 1'b0;
    if (req == 2'b11) begin
      grant = ~last_grant_q;
    end else begin
      grant = req[1];
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    last_grant_d = last_grant_q;
    cur_d        = cur_q;
    ack_d        = 2'b00;
    done_d       = 2'b00;
    err_d        = 1'b0;
    tx_en_d      = tx_en_q;
    tx_data_d    = tx_data_q;

    case (state_q)
      S_IDLE: begin
        tx_en_d = 1'b0;
        if (|req) begin
          cur_d        = grant;
          last_grant_d = grant;
          ack_d[grant] = 1'b1;
          tx_data_d    = build_frame(grant ? payload1 : payload0);
          tx_en_d      = 1'b1;
          timer_d      = 16'd0;
          state_d      = S_SEND;
        end
      end
      S_SEND: begin
        timer_d = timer_q + 16'd1;
        // Completion takes priority over a coincident timeout.
        if (!tx_int_n) begin
          tx_en_d       = 1'b0;
          done_d[cur_q] = 1'b1;
          timer_d       = 16'd0;
          state_d       = S_GAP;
        end else if (timer_q == TO_LAST) begin
          tx_en_d = 1'b0;
          err_d   = 1'b1;
          timer_d = 16'd0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        tx_en_d = 1'b0;
        timer_d = timer_q + 16'd1;
        if (timer_q == GAP_LAST) begin
          timer_d = 16'd0;
          state_d = S_IDLE;
        end
      end
      default: begin
        tx_en_d = 1'b0;
        timer_d = 16'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      timer_q      <= 16'd0;
      last_grant_q <= 1'b1;
      cur_q        <= 1'b0;
      ack_q        <= 2'b00;
      done_q       <= 2'b00;
      err_q        <= 1'b0;
      tx_en_q      <= 1'b0;
      tx_data_q    <= 26'd0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      last_grant_q <= last_grant_d;
      cur_q        <= cur_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      err_q        <= err_d;
      tx_en_q      <= tx_en_d;
      tx_data_q    <= tx_data_d;
    end
  end

  assign ack     = ack_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = (state_q != S_IDLE);
  assign tx_en   = tx_en_q;
  assign tx_data = tx_data_q;

endmodule

// File: tb/tb_wiegand_tx_ctrl.sv
// Directed bench for wiegand_tx_ctrl: grant/arbitration, frame build, completion,
// timeout, gap length, async reset. Inputs change and outputs are sampled on negedge.
module tb_wiegand_tx_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [23:0] payload0;
  logic [23:0] payload1;
  logic [1:0]  ack;
  logic [1:0]  done;
  logic        err;
  logic        busy;
  logic        tx_en;
  logic [25:0] tx_data;
  logic        tx_int_n;

  int tests  = 0;
  int failed = 0;

  wiegand_tx_ctrl #(.GAP_CYCLES(1000), .TIMEOUT(3000)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .payload0 (payload0),
    .payload1 (payload1),
    .ack      (ack),
    .done     (done),
    .err      (err),
    .busy     (busy),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .tx_int_n (tx_int_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},   32'(ack),     32'h0);
    chk({tag, "_done"},  32'(done),    32'h0);
    chk({tag, "_err"},   32'(err),     32'h0);
    chk({tag, "_busy"},  32'(busy),    32'h0);
    chk({tag, "_tx_en"}, 32'(tx_en),   32'h0);
    chk({tag, "_data"},  32'(tx_data), 32'h0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req = 2'b00; payload0 = 24'h0; payload1 = 24'h0; tx_int_n = 1'b1;
    step(2);
    chk_all_zero("reset");
    rst = 1'b1;
    step(1);

    // Frame 1: single request from requester 0, completion at SEND cycle 2210.
    req = 2'b01; payload0 = 24'h123456;
    step(1);
    chk("t1_ack",   32'(ack),     32'h1);
    chk("t1_tx_en", 32'(tx_en),   32'h1);
    chk("t1_data",  32'(tx_data), 32'h0D45890);
    chk("t1_busy",  32'(busy),    32'h1);
    req = 2'b00;
    step(1);
    chk("t1_ack_pulse", 32'(ack), 32'h0);
    step(2209);
    chk("t1_pre_done", 32'(done),  32'h0);
    chk("t1_pre_en",   32'(tx_en), 32'h1);
    tx_int_n = 1'b0;
    step(1);
    chk("t1_done",   32'(done),  32'h1);
    chk("t1_en_off", 32'(tx_en), 32'h0);
    chk("t1_no_err", 32'(err),   32'h0);
    tx_int_n = 1'b1;
    step(1);
    chk("t1_done_pulse", 32'(done), 32'h0);

    // Async reset in GAP restores last_grant and clears outputs at once.
    rst = 1'b0;
    #1;
    chk_all_zero("rst_gap");
    step(1);
    rst = 1'b1;

    // Tie from reset: requester 0 first, then 1, then 0 again.
    req = 2'b11; payload0 = 24'hAAAAAA; payload1 = 24'h555555;
    step(1);
    chk("t2_ack0",  32'(ack),     32'h1);
    chk("t2_data0", 32'(tx_data), 32'h2AAAAAA);
    req = 2'b10;
    tx_int_n = 1'b0;
    step(1);
    chk("t2_done0", 32'(done), 32'h1);
    tx_int_n = 1'b0;  // low during GAP and IDLE: must be ignored
    step(999);
    chk("t2_gap_busy", 32'(busy), 32'h1);
    chk("t2_gap_ack",  32'(ack),  32'h0);
    chk("t2_gap_done", 32'(done), 32'h0);
    step(1);
    chk("t2_idle_busy", 32'(busy), 32'h0);
    chk("t2_idle_done", 32'(done), 32'h0);
    chk("t2_idle_ack",  32'(ack),  32'h0);
    tx_int_n = 1'b1;
    step(1);
    chk("t2_ack1",  32'(ack),     32'h2);
    chk("t2_data1", 32'(tx_data), 32'h3555554);
    req = 2'b11; payload0 = 24'h000000;
    tx_int_n = 1'b0;
    step(1);
    chk("t2_done1", 32'(done), 32'h2);
    tx_int_n = 1'b1;
    step(1000);
    chk("t2_idle2", 32'(busy), 32'h0);
    step(1);
    chk("t2_ack_alt", 32'(ack),     32'h1);
    chk("t4_zero",    32'(tx_data), 32'h2000000);
    req = 2'b00;

    // Timeout: tx_int_n held high for the whole SEND phase.
    step(2999);
    chk("t3_pre_err", 32'(err),   32'h0);
    chk("t3_pre_en",  32'(tx_en), 32'h1);
    step(1);
    chk("t3_err",     32'(err),   32'h1);
    chk("t3_en_off",  32'(tx_en), 32'h0);
    chk("t3_no_done", 32'(done),  32'h0);
    chk("t3_busy",    32'(busy),  32'h1);
    step(1);
    chk("t3_err_pulse", 32'(err), 32'h0);
    step(998);
    chk("t3_gap_end", 32'(busy), 32'h1);
    step(1);
    chk("t3_idle", 32'(busy), 32'h0);

    // All-ones payload; completion coincides with the timeout cycle.
    req = 2'b01; payload0 = 24'hFFFFFF;
    step(1);
    chk("t4_ones_ack", 32'(ack),     32'h1);
    chk("t4_ones",     32'(tx_data), 32'h3FFFFFE);
    req = 2'b00;
    step(2999);
    tx_int_n = 1'b0;
    step(1);
    chk("t6_edge_done", 32'(done),  32'h1);
    chk("t6_edge_err",  32'(err),   32'h0);
    chk("t6_edge_en",   32'(tx_en), 32'h0);
    tx_int_n = 1'b1;
    step(1000);
    chk("t6_idle", 32'(busy), 32'h0);

    // Single upper-half bit sets the leading parity; reset mid-SEND.
    req = 2'b01; payload0 = 24'h001000;
    step(1);
    chk("t4_bit12_ack", 32'(ack),     32'h1);
    chk("t4_bit12",     32'(tx_data), 32'h2001001);
    req = 2'b00;
    step(500);
    chk("t5_pre_en", 32'(tx_en), 32'h1);
    req = 2'b10;
    rst = 1'b0;
    #1;
    chk_all_zero("t5_rst");
    step(1);
    rst = 1'b1;
    step(1);
    chk("t5_ack", 32'(ack),   32'h2);
    chk("t5_en",  32'(tx_en), 32'h1);
    req = 2'b00;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
